// File: rtl/func_stage_pkg.sv
// func_stage_pkg: shared state type and default sizing for the func pipeline stages
package func_stage_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 10;
    localparam int COUNT_DEF  = 8;
    localparam int COUNT_MAX  = 255;
endpackage

// File: rtl/func_acc_sat_add.sv
// func_acc_sat_add: combinational saturating add of a zero-extended sample into an accumulator
module func_acc_sat_add #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 10
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] data,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    logic [ACC_W:0] full;
    assign full = {1'b0, acc} + {{(ACC_W+1-DATA_W){1'b0}}, data};
    assign ovf  = full[ACC_W];
    assign sum  = ovf ? '1 : full[ACC_W-1:0];
endmodule

// File: rtl/func_acc_stage.sv
// func_acc_stage: sums COUNT handshaked samples into a saturating block sum with sticky overflow
module func_acc_stage
    import func_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COUNT  = COUNT_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy,
    output logic [7:0]        sample_cnt
);
    localparam logic [7:0] LAST_M1 = 8'(COUNT - 1);
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [7:0]       cnt;
    logic             ovf;
    logic             accept;
    func_acc_sat_add #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_add (
        .acc (acc),
        .data(in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );
    assign in_ready     = (state != DONE) & ~clear;
    assign accept       = in_valid & in_ready;
    // clear masks out_valid so a clear/out_ready collision never looks like a transfer
    assign out_valid    = (state == DONE) & ~clear;
    assign out_sum      = acc;
    assign out_overflow = ovf;
    assign busy         = state != IDLE;
    assign sample_cnt   = cnt;
    // acc and cnt are zero in IDLE, so the first sample shares the ACCUM add path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear || (state == DONE && out_ready)) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            state <= (cnt == LAST_M1) ? DONE : ACCUM;
            acc   <= add_sum;
            cnt   <= cnt + 8'd1;
            ovf   <= ovf | add_ovf;
        end
    end
endmodule

// File: tb/tb_func_acc_stage.sv
// tb_func_acc_stage: directed-vector self-checking bench for func_acc_stage
module tb_func_acc_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       clear = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_sum;
    logic       out_overflow;
    logic       busy;
    logic [7:0] sample_cnt;
    int         n_cmp = 0;
    int         n_err = 0;
    int         xfers = 0;
    logic [9:0] xfer_sum = '0;
    logic       xfer_ovf = 1'b0;

    func_acc_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_overflow(out_overflow), .busy(busy), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            xfers    <= xfers + 1;
            xfer_sum <= out_sum;
            xfer_ovf <= out_overflow;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_ovf", out_overflow, 0);
        #3 rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // nominal block 2,4,...,16
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(8'(2 * i));
        chk("nom_busy_mid", busy, 1);
        chk("nom_cnt_mid", sample_cnt, 4);
        for (int i = 5; i <= 8; i++) send(8'(2 * i));
        chk("nom_valid", out_valid, 1);
        chk("nom_sum", out_sum, 72);
        chk("nom_ovf", out_overflow, 0);
        chk("nom_busy_done", busy, 1);
        chk("nom_in_ready_done", in_ready, 0);
        step();
        chk("nom_busy_after", busy, 0);
        chk("nom_valid_after", out_valid, 0);
        chk("nom_xfers", xfers, 1);
        chk("nom_xfer_sum", xfer_sum, 72);

        // saturation with backpressure in DONE
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'hFE);
        chk("sat_clamp5", out_sum, 1023);
        chk("sat_ovf5", out_overflow, 1);
        for (int i = 0; i < 3; i++) send(8'hFE);
        chk("sat_valid", out_valid, 1);
        chk("sat_sum", out_sum, 1023);
        chk("sat_ovf", out_overflow, 1);
        in_valid = 1'b1;
        in_data  = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 1023);
            chk("bp_ovf", out_overflow, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_cnt", sample_cnt, 8);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("sat_xfers", xfers, 2);
        chk("sat_xfer_sum", xfer_sum, 1023);
        chk("sat_xfer_ovf", xfer_ovf, 1);
        chk("bp_idle_cnt", sample_cnt, 0);
        chk("bp_idle_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) send(8'd1);
        chk("ones_valid", out_valid, 1);
        chk("ones_sum", out_sum, 8);
        chk("ones_ovf", out_overflow, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ones_xfers", xfers, 3);
        chk("ones_xfer_sum", xfer_sum, 8);

        // gapped input: valid on alternate cycles
        in_data = 8'd5;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            step();
            if (i == 5) chk("gap_cnt_mid", sample_cnt, 3);
        end
        in_valid = 1'b0;
        chk("gap_cnt", sample_cnt, 8);
        chk("gap_sum", out_sum, 40);
        chk("gap_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("gap_xfers", xfers, 4);
        chk("gap_xfer_sum", xfer_sum, 40);

        // clear mid-block rejects the concurrent sample
        for (int i = 0; i < 3; i++) send(8'd10);
        chk("clr_pre_sum", out_sum, 30);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd10;
        #1;
        chk("clr_in_ready", in_ready, 0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", sample_cnt, 0);
        chk("clr_sum", out_sum, 0);
        chk("clr_busy", busy, 0);
        for (int i = 0; i < 8; i++) send(8'd1);
        chk("clr_next_sum", out_sum, 8);
        chk("clr_next_valid", out_valid, 1);

        // clear collides with out_ready in DONE
        clear     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("cvh_valid_masked", out_valid, 0);
        step();
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("cvh_xfers", xfers, 4);
        chk("cvh_valid", out_valid, 0);
        chk("cvh_busy", busy, 0);
        chk("cvh_cnt", sample_cnt, 0);

        // asynchronous reset while in DONE
        for (int i = 0; i < 8; i++) send(8'd2);
        chk("ar_pre_valid", out_valid, 1);
        chk("ar_pre_sum", out_sum, 16);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_sum", out_sum, 0);
        chk("ar_busy", busy, 0);
        #3 rst_n = 1'b1;
        step();
        chk("ar_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) send(8'd3);
        chk("ar_next_sum", out_sum, 24);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ar_xfers", xfers, 5);
        chk("ar_xfer_sum", xfer_sum, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
